// File: rtl/ps2_host_ctrl.sv
// PS/2 host-side command sequencer: arbitrates init/LED commands, drives the
// open-drain clock/data enables for host-to-device frames and checks replies.
`timescale 1ns/1ps
module ps2_host_ctrl #(
    parameter int unsigned INHIBIT_CYC  = 2500,
    parameter int unsigned BIT_TIMEOUT  = 50000,
    parameter int unsigned RESP_TIMEOUT = 500000,
    parameter int unsigned BAT_TIMEOUT  = 25000000,
    parameter int unsigned RETRIES      = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       rx_block,
    input  logic       init_req,
    input  logic       led_req,
    input  logic [2:0] led_val,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       kbd_ok
);

    localparam int TW = 25;
    localparam int AW = $clog2(RETRIES + 1);
    localparam logic [TW-1:0] INH_LD  = TW'(INHIBIT_CYC - 1);
    localparam logic [TW-1:0] BIT_LD  = TW'(BIT_TIMEOUT - 1);
    localparam logic [TW-1:0] RESP_LD = TW'(RESP_TIMEOUT - 1);
    localparam logic [TW-1:0] BAT_LD  = TW'(BAT_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, INHIBIT, START, TX_BITS, TX_ACK, WAIT_RESP, WAIT_BAT
    } state_t;

    state_t         state, state_n;
    logic [TW-1:0]  tmr, tmr_n;
    logic [3:0]     bit_cnt, bit_cnt_n;
    logic [AW-1:0]  att, att_n, att_inc;
    logic           byte_sel, byte_sel_n;
    logic           cmd_init, cmd_init_n;
    logic [2:0]     led_byte, led_byte_n;
    logic           init_pend, init_pend_n, led_pend, led_pend_n;
    logic           dat_oe_q, dat_oe_n;
    logic           done_q, done_n, err_q, err_n, kbd_ok_q, kbd_ok_n;
    logic           fail, init_want, led_want;
    logic [7:0]     tx_byte;

    // Two-flop synchronisers; sync resets to idle-high so reset never looks like an edge.
    logic [1:0] clk_sync, dat_sync;
    logic       clk_prev, fall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            clk_prev <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk_i};
            dat_sync <= {dat_sync[0], ps2_dat_i};
            clk_prev <= clk_sync[1];
        end
    end

    assign fall    = clk_prev & ~clk_sync[1];
    assign tx_byte = cmd_init ? 8'hFF : (byte_sel ? {5'b0, led_byte} : 8'hED);
    assign att_inc = att + AW'(1);

    // Pulses in the current cycle count as pending so IDLE can launch on the next edge.
    assign init_want = init_pend | init_req;
    assign led_want  = led_pend | led_req;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            tmr       <= '0;
            bit_cnt   <= '0;
            att       <= '0;
            byte_sel  <= 1'b0;
            cmd_init  <= 1'b0;
            led_byte  <= '0;
            init_pend <= 1'b1;
            led_pend  <= 1'b0;
            dat_oe_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            kbd_ok_q  <= 1'b0;
        end else begin
            state     <= state_n;
            tmr       <= tmr_n;
            bit_cnt   <= bit_cnt_n;
            att       <= att_n;
            byte_sel  <= byte_sel_n;
            cmd_init  <= cmd_init_n;
            led_byte  <= led_byte_n;
            init_pend <= init_pend_n;
            led_pend  <= led_pend_n;
            dat_oe_q  <= dat_oe_n;
            done_q    <= done_n;
            err_q     <= err_n;
            kbd_ok_q  <= kbd_ok_n;
        end
    end

    always_comb begin
        state_n     = state;
        tmr_n       = (tmr != '0) ? tmr - TW'(1) : tmr;
        bit_cnt_n   = bit_cnt;
        att_n       = att;
        byte_sel_n  = byte_sel;
        cmd_init_n  = cmd_init;
        led_byte_n  = led_byte;
        init_pend_n = init_want;
        led_pend_n  = led_want;
        dat_oe_n    = dat_oe_q;
        done_n      = 1'b0;
        err_n       = err_q;
        kbd_ok_n    = kbd_ok_q;
        fail        = 1'b0;

        case (state)
            IDLE: begin
                dat_oe_n = 1'b0;
                if (init_want || led_want) begin
                    state_n    = INHIBIT;
                    tmr_n      = INH_LD;
                    att_n      = '0;
                    byte_sel_n = 1'b0;
                    err_n      = 1'b0;
                    if (init_want) begin
                        cmd_init_n  = 1'b1;
                        init_pend_n = 1'b0;
                    end else begin
                        cmd_init_n = 1'b0;
                        led_pend_n = 1'b0;
                        led_byte_n = led_val;
                    end
                end
            end
            INHIBIT: begin
                if (tmr == '0) begin
                    state_n  = START;
                    dat_oe_n = 1'b1;
                end
            end
            START: begin
                state_n   = TX_BITS;
                tmr_n     = BIT_LD;
                bit_cnt_n = '0;
            end
            TX_BITS: begin
                if (fall) begin
                    tmr_n     = BIT_LD;
                    bit_cnt_n = bit_cnt + 4'd1;
                    if (bit_cnt < 4'd8) begin
                        dat_oe_n = ~tx_byte[bit_cnt[2:0]];
                    end else if (bit_cnt == 4'd8) begin
                        dat_oe_n = ~(~^tx_byte);
                    end else begin
                        dat_oe_n = 1'b0;
                        state_n  = TX_ACK;
                    end
                end else if (tmr == '0) begin
                    fail = 1'b1;
                end
            end
            TX_ACK: begin
                if (fall) begin
                    if (!dat_sync[1]) begin
                        state_n = WAIT_RESP;
                        tmr_n   = RESP_LD;
                    end else begin
                        fail = 1'b1;
                    end
                end else if (tmr == '0) begin
                    fail = 1'b1;
                end
            end
            WAIT_RESP: begin
                if (rx_valid && rx_data == 8'hFA) begin
                    att_n = '0;
                    if (cmd_init) begin
                        state_n = WAIT_BAT;
                        tmr_n   = BAT_LD;
                    end else if (!byte_sel) begin
                        byte_sel_n = 1'b1;
                        state_n    = INHIBIT;
                        tmr_n      = INH_LD;
                    end else begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end
                end else if ((rx_valid && rx_data == 8'hFE) || tmr == '0) begin
                    fail = 1'b1;
                end
            end
            WAIT_BAT: begin
                if (rx_valid && rx_data == 8'hAA) begin
                    kbd_ok_n = 1'b1;
                    done_n   = 1'b1;
                    state_n  = IDLE;
                end else if ((rx_valid && rx_data == 8'hFC) || tmr == '0) begin
                    err_n    = 1'b1;
                    kbd_ok_n = 1'b0;
                    state_n  = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        // Any failed attempt releases data; retry the same byte until attempts run out.
        if (fail) begin
            dat_oe_n = 1'b0;
            att_n    = att_inc;
            if (att_inc < AW'(RETRIES)) begin
                state_n = INHIBIT;
                tmr_n   = INH_LD;
            end else begin
                state_n = IDLE;
                err_n   = 1'b1;
                if (cmd_init) kbd_ok_n = 1'b0;
            end
        end
    end

    assign ps2_clk_oe = (state == INHIBIT) || (state == START);
    assign ps2_dat_oe = dat_oe_q;
    assign rx_block   = (state == INHIBIT) || (state == START) ||
                        (state == TX_BITS) || (state == TX_ACK);
    assign busy       = (state != IDLE);
    assign done       = done_q;
    assign err        = err_q;
    assign kbd_ok     = kbd_ok_q;

endmodule

// File: tb/tb_ps2_host_ctrl.sv
// Bench for ps2_host_ctrl: a keyboard model on the open-drain pins plus a
// table of directed commands and hand-written multi-cycle sequences.
`timescale 1ns/1ps
module tb_ps2_host_ctrl;

    localparam int INH    = 40;
    localparam int BITTO  = 300;
    localparam int RESPTO = 1500;
    localparam int BATTO  = 3000;
    localparam int HALF   = 20;

    logic       clk, rst;
    logic       ps2_clk_i, ps2_dat_i, ps2_clk_oe, ps2_dat_oe;
    logic       rx_valid, rx_block, init_req, led_req;
    logic [7:0] rx_data;
    logic [2:0] led_val;
    logic       busy, done, err, kbd_ok;
    logic       dev_clk_low, dev_dat_low;

    int vec = 0;
    int bad = 0;

    ps2_host_ctrl #(
        .INHIBIT_CYC(INH), .BIT_TIMEOUT(BITTO), .RESP_TIMEOUT(RESPTO),
        .BAT_TIMEOUT(BATTO), .RETRIES(3)
    ) dut (
        .clk(clk), .rst(rst),
        .ps2_clk_i(ps2_clk_i), .ps2_dat_i(ps2_dat_i),
        .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_block(rx_block),
        .init_req(init_req), .led_req(led_req), .led_val(led_val),
        .busy(busy), .done(done), .err(err), .kbd_ok(kbd_ok)
    );

    // Open-drain wired-AND of host and device pull-downs.
    assign ps2_clk_i = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_dat_i = ~(ps2_dat_oe | dev_dat_low);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic resp(input logic [7:0] r, input int dly);
        repeat (dly) @(negedge clk);
        rx_data  = r;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = '0;
    endtask

    // Device side of one host-to-device frame; returns the 8 data bits and parity.
    task automatic dev_rx(output logic [7:0] b, output logic p);
        int n;
        logic [9:0] sh;
        b = '0; p = 1'b0; sh = '0; n = 0;
        while (!ps2_clk_oe && n < 8000) begin @(negedge clk); n++; end
        if (!ps2_clk_oe) begin
            vec++; bad++;
            $display("FAIL inhibit_wait: got no clk_oe expected clk_oe=1");
            return;
        end
        chk("rx_block_tx", rx_block, 1);
        n = 0;
        while (ps2_clk_oe && n < 8000) begin n++; @(negedge clk); end
        chk("inhibit_len", n, INH + 1);
        chk("start_bit", ps2_dat_oe, 1);
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            sh[i] = ps2_dat_i;
            dev_clk_low = 1'b0;
            repeat (HALF) @(negedge clk);
        end
        chk("stop_bit", sh[9], 1);
        dev_dat_low = 1'b1;
        repeat (3) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (HALF) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (4) @(negedge clk);
        dev_dat_low = 1'b0;
        chk("rx_block_ack", rx_block, 0);
        b = sh[7:0];
        p = sh[8];
    endtask

    task automatic pulse(input logic i, input logic l);
        init_req = i;
        led_req  = l;
        @(negedge clk);
        init_req = 1'b0;
        led_req  = 1'b0;
    endtask

    // Device side of a whole command that has already been launched.
    task automatic do_cmd(input logic is_init, input logic [7:0] b1, input logic p1,
                          input logic fe, input logic poke, input int bat_dly);
        logic [7:0] b, b0;
        logic p;
        b0 = is_init ? 8'hFF : 8'hED;
        dev_rx(b, p);
        chk("byte0", b, b0);
        chk("par0", p, 1);
        if (fe) begin
            resp(8'hFE, 20);
            dev_rx(b, p);
            chk("resend", b, b0);
        end
        if (poke && !is_init) begin
            repeat (5) @(negedge clk);
            pulse(1'b1, 1'b0);
            repeat (5) @(negedge clk);
            pulse(1'b1, 1'b0);
        end
        resp(8'hFA, 20);
        if (is_init) begin
            if (poke) begin
                repeat (30) @(negedge clk);
                pulse(1'b0, 1'b1);
                repeat (30) @(negedge clk);
                chk("no_preempt", {busy, ps2_clk_oe}, 2'b10);
            end
            resp(8'hAA, bat_dly);
        end else begin
            dev_rx(b, p);
            chk("byte1", b, b1);
            chk("par1", p, p1);
            resp(8'hFA, 20);
        end
        chk("done", done, 1);
        chk("busy_end", busy, 0);
        chk("err_end", err, 0);
        if (is_init) chk("kbd_ok", kbd_ok, 1);
        @(negedge clk);
        chk("done_pulse", done, 0);
    endtask

    typedef struct {
        logic       is_init;
        logic [2:0] lv;
        logic       fe;
        logic [7:0] b1;
        logic       p1;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int n, rises;
        logic prev;

        tbl[0] = '{1'b0, 3'b101, 1'b0, 8'h05, 1'b1};
        tbl[1] = '{1'b0, 3'b010, 1'b1, 8'h02, 1'b0};
        tbl[2] = '{1'b0, 3'b111, 1'b0, 8'h07, 1'b0};
        tbl[3] = '{1'b1, 3'b000, 1'b1, 8'h00, 1'b0};
        tbl[4] = '{1'b0, 3'b000, 1'b0, 8'h00, 1'b1};

        rst = 1'b0; rx_valid = 1'b0; rx_data = '0;
        init_req = 1'b0; led_req = 1'b0; led_val = '0;
        dev_clk_low = 1'b0; dev_dat_low = 1'b0;

        // Reset state and automatic init.
        repeat (3) @(negedge clk);
        chk("rst_clk_oe", ps2_clk_oe, 0);
        chk("rst_dat_oe", ps2_dat_oe, 0);
        chk("rst_rx_block", rx_block, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_kbd_ok", kbd_ok, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("auto_busy", busy, 1);
        chk("auto_clk_oe", ps2_clk_oe, 1);
        do_cmd(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1000);

        // Table of single commands; led_val is disturbed once the command is under way.
        foreach (tbl[k]) begin
            led_val = tbl[k].lv;
            pulse(tbl[k].is_init, ~tbl[k].is_init);
            chk("req_to_clk_oe", ps2_clk_oe, 1);
            led_val = ~tbl[k].lv;
            do_cmd(tbl[k].is_init, tbl[k].b1, tbl[k].p1, tbl[k].fe, 1'b0, 200);
        end

        // No device: the clock never toggles.
        pulse(1'b1, 1'b0);
        n = 0; rises = 0; prev = 1'b0;
        while (busy && n < 6000) begin
            if (ps2_clk_oe && !prev) rises++;
            prev = ps2_clk_oe;
            @(negedge clk);
            n++;
        end
        chk("nodev_attempts", rises, 3);
        chk("nodev_busy", busy, 0);
        chk("nodev_err", err, 1);
        chk("nodev_oe", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
        chk("nodev_kbd_ok", kbd_ok, 0);

        // Arbitration: led during WAIT_BAT, double init during the LED command.
        led_val = 3'b011;
        pulse(1'b1, 1'b0);
        chk("err_cleared", err, 0);
        do_cmd(1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 200);
        do_cmd(1'b0, 8'h03, 1'b1, 1'b0, 1'b1, 0);
        do_cmd(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 200);
        repeat (50) @(negedge clk);
        chk("merged_idle", busy, 0);

        // Simultaneous requests: init first, then led.
        pulse(1'b1, 1'b1);
        do_cmd(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 200);
        do_cmd(1'b0, 8'h03, 1'b1, 1'b0, 1'b0, 0);

        // Reset during device edge 5 of an ED frame (d4 = 0, so data is driven).
        pulse(1'b0, 1'b1);
        n = 0;
        while (ps2_clk_oe && n < 8000) begin n++; @(negedge clk); end
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b0;
            repeat (HALF) @(negedge clk);
        end
        dev_clk_low = 1'b1;
        repeat (10) @(negedge clk);
        chk("edge5_dat_oe", ps2_dat_oe, 1);
        #1 rst = 1'b0;
        #1;
        chk("rst_async_oe", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
        chk("rst_async_busy", busy, 0);
        dev_clk_low = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("restart_busy", busy, 1);
        chk("restart_kbd_ok", kbd_ok, 0);
        do_cmd(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 200);

        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

endmodule

// File: doc/ps2_host_ctrl.md
# ps2_host_ctrl

Host-side command sequencer for the PS/2 keyboard port. It arbitrates between two command requesters: keyboard init/reset and LED update. It serialises each command byte onto the open-drain PS/2 clock and data lines using the host-to-device protocol, then checks the keyboard's response bytes, which the existing PS/2 receiver delivers. It sits beside the receiver and scan-code matrix logic, owns both pin output-enables, and masks the receiver while the host is transmitting.

## Interface
Parameters:
- INHIBIT_CYC, 2500: clk cycles that ps2 clock is held low before a transmit (≥100 µs).
- BIT_TIMEOUT, 50000: maximum clk cycles between device clock falling edges during a transmit.
- RESP_TIMEOUT, 500000: maximum clk cycles to wait for the FA response.
- BAT_TIMEOUT, 25000000: maximum clk cycles to wait for the AA response after FF.
- RETRIES, 3: number of attempts per byte before the block reports an error.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- ps2_clk_i  in  1  raw PS/2 clock pin; synchronised internally with 2 FFs.
- ps2_dat_i  in  1  raw PS/2 data pin; synchronised internally with 2 FFs.
- ps2_clk_oe  out  1  1 = drive the clock pin low; 0 = release it.
- ps2_dat_oe  out  1  1 = drive the data pin low; 0 = release it.
- rx_valid  in  1  one-cycle strobe from the receiver: a good byte is on rx_data.
- rx_data  in  8  byte received from the keyboard.
- rx_block  out  1  1 while the host is transmitting; the receiver discards any frames received while it is set.
- init_req  in  1  pulse: send FF (reset) and expect FA then AA.
- led_req  in  1  pulse: send ED, then led_val, expecting FA after each byte.
- led_val  in  3  {caps, num, scroll}; sampled when the LED command starts.
- busy  out  1  a command is in progress.
- done  out  1  one-cycle pulse when a command completes successfully.
- err  out  1  sticky error flag; cleared when the next command starts.
- kbd_ok  out  1  set when AA is received; cleared by reset or by a failed init.

## Operation
- Pending flags: init_pend and led_pend latch request pulses, including pulses that arrive while busy.
  - Reset sets init_pend=1, so the block performs an automatic init.
  - A pending flag clears when its command starts.
- Arbitration: fixed priority, init over led, evaluated only in IDLE.
  - A new request never preempts a command in progress.
  - An init request that arrives during an LED command runs immediately after that command.
- Byte FSM states: IDLE → INHIBIT → START → TX_BITS → TX_ACK → WAIT_RESP → (next byte | WAIT_BAT | IDLE).
- INHIBIT: clk_oe=1 for INHIBIT_CYC cycles; rx_block=1.
- START: dat_oe=1 (start bit) while clk_oe stays 1 for one cycle; then clk_oe=0.
- TX_BITS: the block acts on device clock falling edges (synchronised, 1→0).
  - Edges 1–8 present data bits d0..d7, LSB first, with dat_oe=~bit.
  - Edge 9 presents odd parity: dat_oe=~(~^data).
  - Edge 10 releases data for the stop bit: dat_oe=0.
- TX_ACK: on edge 11 the block samples data.
  - 0 = device ack: rx_block drops and the FSM moves to WAIT_RESP.
  - 1 = failed attempt.
- WAIT_RESP: the block waits for an rx_valid byte.
  - FA = ack: the next byte is sent (LED value), the FSM moves to WAIT_BAT (after FF), or the command completes.
  - FE = resend: failed attempt; the same byte is resent.
  - Any other byte: ignored; the wait timer continues.
- WAIT_BAT: AA sets kbd_ok, then done.
  - FC: err, kbd_ok=0.
  - Timeout: err, kbd_ok=0.
- Failed attempts: a failed attempt or a per-stage timeout (BIT_TIMEOUT or RESP_TIMEOUT) releases both lines and increments the attempt counter.
  - If attempts < RETRIES, the FSM restarts at INHIBIT with the same byte.
  - Otherwise it sets err, returns to IDLE and drops the rest of the command.
- LED byte: {5'b0, caps, num, scroll}, latched at command start. A later led_val change does not alter a command in flight.
- Timers: a single 25-bit down-counter, reloaded on every state entry and on every device clock edge in TX_BITS/TX_ACK.

## Timing
- Reset values: ps2_clk_oe=0, ps2_dat_oe=0, rx_block=0, busy=0, done=0, err=0, kbd_ok=0, state=IDLE, attempt counter=0.
- busy rises on the first clk edge after rst deasserts, because of the auto-init.
- Request to start: clk_oe rises 1 cycle after the request is seen in IDLE.
- Inhibit duration: clk_oe stays high for exactly INHIBIT_CYC+1 cycles (including START).
- Edge response: dat_oe updates 3 clk cycles after the pin's falling edge (2 synchroniser stages + 1 register stage).
- Completion: done pulses 1 cycle after the final FA/AA rx_valid; busy falls in the same cycle.
- err: set in the cycle the terminal failure is detected; held until the next command starts.
- Request merging: several pulses of the same request while pending merge into one command.
- Simultaneous requests: init_req and led_req arriving in the same cycle run init, then led.
- Reset mid-transmit: both lines are released immediately (asynchronous), then a fresh auto-init runs.

## Test plan
- Power-up: release rst; the keyboard model acks FF and returns FA, then AA after 1000 cycles. Expect a clk_oe low pulse of 2501 cycles, data bits 0xFF with parity 1, then done=1 and kbd_ok=1.
- LED update: led_req with led_val=3'b101. Expect bytes ED then 0x05 (parity 1) on the wire, each followed by FA, then a single done pulse and err=0.
- Resend: the model answers the first ED with FE. Expect ED retransmitted and the command to complete; err=0.
- No device: nothing toggles the clock. Expect 3 attempts, each ending after BIT_TIMEOUT, then err=1, busy=0, and both oe outputs 0.
- Arbitration: led_req is pulsed during init's WAIT_BAT and init_req is re-pulsed during the LED command. Expect the order init, led, init, with no overlap.
- Reset mid-byte: assert rst at device edge 5. Expect clk_oe=dat_oe=0 immediately, and an FF transmit to restart after release.
